regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Schedules writeback into the 16-bit, 8-entry register file; that file has one write port and r0 hardwired to zero.
- Arbitrates two writeback requesters (A = ALU, B = load unit) onto the single write port using valid/ready handshakes and round-robin priority.
- Keeps a busy scoreboard of destination registers with writes pending, and stalls issue on RAW/WAW hazards.
- Sits between the issue stage, the execution units and the register file's tgt/tgt_dat/we inputs.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 3, register index width.
- NREG, 8, number of registers (2**ADDR_W); index 0 is the zero register.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- iss_valid  input  1  issue stage presents an instruction.
- iss_src1  input  ADDR_W  first source register index.
- iss_src2  input  ADDR_W  second source register index.
- iss_tgt  input  ADDR_W  destination register index.
- iss_stall  output  1  hazard: instruction must not issue this cycle.
- a_valid  input  1  requester A has writeback data.
- a_tgt  input  ADDR_W  requester A destination.
- a_dat  input  DATA_W  requester A data.
- a_ready  output  1  requester A granted this cycle.
- b_valid  input  1  requester B has writeback data.
- b_tgt  input  ADDR_W  requester B destination.
- b_dat  input  DATA_W  requester B data.
- b_ready  output  1  requester B granted this cycle.
- rf_we  output  1  register file write enable (registered).
- rf_tgt  output  ADDR_W  register file write index (registered).
- rf_dat  output  DATA_W  register file write data (registered).
- busy  output  NREG  scoreboard vector; bit i means a write to register i is pending.
- wb_err  output  1  sticky: a write was granted to a register that was not busy.

Behaviour:
- Reset (async, rst_n=0):
  - busy=0, rf_we=0, rf_tgt=0, rf_dat=0, wb_err=0, last_grant=B.
  - Any in-flight registered write is cancelled.
  - a_ready and b_ready are 0 during reset.
- Arbitration (combinational ready, at most one grant per cycle):
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid: grant the requester not in last_grant.
  - last_grant updates on every grant.
  - After reset, A wins the first contention.
- Handshake:
  - A transfer occurs when valid && ready.
  - A requester not granted must hold valid/tgt/dat stable.
  - Grants do not depend on rf_we; the write port accepts one write per cycle.
- Write latency:
  - A transfer in cycle N drives rf_we=1 with the captured tgt/dat in cycle N+1, for exactly one cycle.
  - With no transfer in cycle N, rf_we=0 in cycle N+1; rf_tgt/rf_dat hold their last values.
- Zero register:
  - A transfer with tgt=0 completes the handshake but produces rf_we=0.
  - It does not set wb_err.
- Scoreboard set:
  - On iss_valid && !iss_stall && iss_tgt!=0, set busy[iss_tgt] at the clock edge.
- Scoreboard clear:
  - In a cycle with rf_we=1, clear busy[rf_tgt] at the end of that cycle.
  - If a set and a clear hit the same register in the same edge, set wins.
- Hazard:
  - iss_stall = iss_valid && (busy[iss_src1] || busy[iss_src2] || busy[iss_tgt]), with index 0 terms forced 0.
  - Purely combinational on the current busy vector.
  - No bypass: during the rf_we cycle the register is still busy, so issue stalls one more cycle.
- Error:
  - On a transfer with tgt!=0 where busy[tgt]=0 and the tgt is not being set in the same cycle, wb_err goes to 1.
  - wb_err stays 1 until reset.
- Simultaneous A and B to the same tgt:
  - Serialised by arbitration.
  - The second write raises wb_err if the first write's clear has already taken effect.

Test Plan:
- Reset, then A writes r3=0x1234 with no contention → a_ready=1 in cycle 0; cycle 1: rf_we=1, rf_tgt=3, rf_dat=0x1234; cycle 2: rf_we=0.
- A and B valid together for 4 cycles (A r1=0x0001, then r2; B r5=0xBEEF) → grants A,B,A,B; rf_tgt sequence 1,5,2,5 one cycle later.
- Issue tgt=4 unstalled; next cycle issue src1=4 → iss_stall=1 and busy[4]=1; B writes r4=0x00FF → stall holds through the rf_we cycle, drops the cycle after; busy[4]=0.
- Issue with src1=0, src2=0, tgt=0 while busy=0xFE → iss_stall=0, busy unchanged; A transfer with tgt=0 → rf_we stays 0, wb_err=0.
- A write to r6 while busy[6]=0 → wb_err=1 one cycle later and stays set; assert rst_n=0 mid-write → rf_we, busy and wb_err all 0 immediately.
- Issue tgt=2 in the same cycle as the rf_we for r2 → busy[2] stays 1 (set wins).

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for an 8 x 16-bit register file: round-robin arbitration of two
// writeback requesters onto one registered write port, plus a busy scoreboard for issue hazards.
`timescale 1ns/1ps

module regfile_wb_scheduler #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_src1,
    input  logic [ADDR_W-1:0] iss_src2,
    input  logic [ADDR_W-1:0] iss_tgt,
    output logic              iss_stall,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_tgt,
    input  logic [DATA_W-1:0] a_dat,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_tgt,
    input  logic [DATA_W-1:0] b_dat,
    output logic              b_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_tgt,
    output logic [DATA_W-1:0] rf_dat,
    output logic [NREG-1:0]   busy,
    output logic              wb_err
);

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    // One-hot decode of a register index; the zero register never maps to a scoreboard bit.
    function automatic logic [NREG-1:0] reg_mask(input logic [ADDR_W-1:0] idx);
        logic [NREG-1:0] m;
        m = {{(NREG-1){1'b0}}, 1'b1} << idx;
        m[0] = 1'b0;
        return m;
    endfunction

    logic              last_grant_q, last_grant_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_tgt_q, rf_tgt_d;
    logic [DATA_W-1:0] rf_dat_q, rf_dat_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              wb_err_q, wb_err_d;

    logic              xfer_s;
    logic [ADDR_W-1:0] sel_tgt_s;
    logic [DATA_W-1:0] sel_dat_s;
    logic [NREG-1:0]   set_s;
    logic [NREG-1:0]   clr_s;
    logic [NREG-1:0]   hazard_s;
    logic              err_s;

    // Round-robin arbitration: contention goes to whichever requester was not granted last.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst_n) begin
            a_ready = 1'b0;
            b_ready = 1'b0;
        end else if (a_valid && b_valid) begin
            if (last_grant_q == GRANT_B) begin
                a_ready = 1'b1;
            end else begin
                b_ready = 1'b1;
            end
        end else begin
            a_ready = a_valid;
            b_ready = b_valid;
        end
    end

    // Select the granted requester's payload.
    always_comb begin
        xfer_s    = a_ready || b_ready;
        sel_tgt_s = {ADDR_W{1'b0}};
        sel_dat_s = {DATA_W{1'b0}};
        if (a_ready) begin
            sel_tgt_s = a_tgt;
            sel_dat_s = a_dat;
        end else if (b_ready) begin
            sel_tgt_s = b_tgt;
            sel_dat_s = b_dat;
        end else begin
            sel_tgt_s = {ADDR_W{1'b0}};
            sel_dat_s = {DATA_W{1'b0}};
        end
    end

    // Hazard detection works on the registered busy vector only, so there is no bypass.
    always_comb begin
        hazard_s  = reg_mask(iss_src1) | reg_mask(iss_src2) | reg_mask(iss_tgt);
        iss_stall = iss_valid && ((hazard_s & busy_q) != {NREG{1'b0}});
    end

    // Scoreboard update; OR-ing the set after the clear makes a same-edge set win.
    always_comb begin
        set_s  = {NREG{1'b0}};
        clr_s  = {NREG{1'b0}};
        if (iss_valid && !iss_stall) begin
            set_s = reg_mask(iss_tgt);
        end else begin
            set_s = {NREG{1'b0}};
        end
        if (rf_we_q) begin
            clr_s = reg_mask(rf_tgt_q);
        end else begin
            clr_s = {NREG{1'b0}};
        end
        busy_d = (busy_q & ~clr_s) | set_s;
    end

    // Write-port next state, grant history and the sticky unexpected-write flag.
    always_comb begin
        rf_we_d      = 1'b0;
        rf_tgt_d     = rf_tgt_q;
        rf_dat_d     = rf_dat_q;
        last_grant_d = last_grant_q;
        err_s        = 1'b0;
        if (xfer_s && (sel_tgt_s != {ADDR_W{1'b0}})) begin
            rf_we_d  = 1'b1;
            rf_tgt_d = sel_tgt_s;
            rf_dat_d = sel_dat_s;
            err_s    = ((reg_mask(sel_tgt_s) & (busy_q | set_s)) == {NREG{1'b0}});
        end else begin
            rf_we_d  = 1'b0;
            err_s    = 1'b0;
        end
        if (a_ready) begin
            last_grant_d = GRANT_A;
        end else if (b_ready) begin
            last_grant_d = GRANT_B;
        end else begin
            last_grant_d = last_grant_q;
        end
        wb_err_d = wb_err_q || err_s;
    end

    // State registers; reset also cancels any write captured for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_B;
            rf_we_q      <= 1'b0;
            rf_tgt_q     <= {ADDR_W{1'b0}};
            rf_dat_q     <= {DATA_W{1'b0}};
            busy_q       <= {NREG{1'b0}};
            wb_err_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_tgt_q     <= rf_tgt_d;
            rf_dat_q     <= rf_dat_d;
            busy_q       <= busy_d;
            wb_err_q     <= wb_err_d;
        end
    end

    assign rf_we  = rf_we_q;
    assign rf_tgt = rf_tgt_q;
    assign rf_dat = rf_dat_q;
    assign busy   = busy_q;
    assign wb_err = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: linear steps with hand-computed expectations.
`timescale 1ns/1ps

module tb_regfile_wb_scheduler;

    logic        clk;
    logic        rst_n;
    logic        iss_valid;
    logic [2:0]  iss_src1, iss_src2, iss_tgt;
    logic        iss_stall;
    logic        a_valid, b_valid;
    logic [2:0]  a_tgt, b_tgt;
    logic [15:0] a_dat, b_dat;
    logic        a_ready, b_ready;
    logic        rf_we;
    logic [2:0]  rf_tgt;
    logic [15:0] rf_dat;
    logic [7:0]  busy;
    logic        wb_err;

    int vectors;
    int miscompares;

    regfile_wb_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_tgt(iss_tgt),
        .iss_stall(iss_stall),
        .a_valid(a_valid), .a_tgt(a_tgt), .a_dat(a_dat), .a_ready(a_ready),
        .b_valid(b_valid), .b_tgt(b_tgt), .b_dat(b_dat), .b_ready(b_ready),
        .rf_we(rf_we), .rf_tgt(rf_tgt), .rf_dat(rf_dat), .busy(busy), .wb_err(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rstp_rf_we", 32'(rf_we), 32'h0);
        check("rstp_busy", 32'(busy), 32'h0);
        check("rstp_wb_err", 32'(wb_err), 32'h0);
        check("rstp_rf_tgt", 32'(rf_tgt), 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        iss_valid = 1'b0; iss_src1 = 3'd0; iss_src2 = 3'd0; iss_tgt = 3'd0;
        a_valid = 1'b1; a_tgt = 3'd0; a_dat = 16'h0000;
        b_valid = 1'b0; b_tgt = 3'd0; b_dat = 16'h0000;
        #3;
        check("rst_a_ready", 32'(a_ready), 32'h0);
        check("rst_rf_we", 32'(rf_we), 32'h0);
        check("rst_rf_tgt", 32'(rf_tgt), 32'h0);
        check("rst_rf_dat", 32'(rf_dat), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_wb_err", 32'(wb_err), 32'h0);
        a_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // Single uncontended write of r3 after issuing r3.
        iss_valid = 1'b1; iss_tgt = 3'd3;
        #1 check("t1_stall", 32'(iss_stall), 32'h0);
        tick();
        iss_valid = 1'b0; iss_tgt = 3'd0;
        a_valid = 1'b1; a_tgt = 3'd3; a_dat = 16'h1234;
        #1;
        check("t1_busy_set", 32'(busy), 32'h08);
        check("t1_a_ready", 32'(a_ready), 32'h1);
        check("t1_b_ready", 32'(b_ready), 32'h0);
        tick();
        a_valid = 1'b0;
        #1;
        check("t1_rf_we", 32'(rf_we), 32'h1);
        check("t1_rf_tgt", 32'(rf_tgt), 32'h3);
        check("t1_rf_dat", 32'(rf_dat), 32'h1234);
        check("t1_busy_hold", 32'(busy), 32'h08);
        check("t1_wb_err", 32'(wb_err), 32'h0);
        tick();
        #1;
        check("t1_rf_we_off", 32'(rf_we), 32'h0);
        check("t1_busy_clr", 32'(busy), 32'h00);
        check("t1_rf_tgt_hold", 32'(rf_tgt), 32'h3);

        // Reset restores last_grant=B, so A must win the next contention.
        pulse_reset();

        iss_valid = 1'b1; iss_tgt = 3'd1; tick();
        iss_tgt = 3'd2; tick();
        iss_tgt = 3'd5; tick();
        iss_valid = 1'b0; iss_tgt = 3'd0;
        a_valid = 1'b1; a_tgt = 3'd1; a_dat = 16'h0001;
        b_valid = 1'b1; b_tgt = 3'd5; b_dat = 16'hBEEF;
        #1;
        check("t2_busy", 32'(busy), 32'h26);
        check("t2_g1_a", 32'(a_ready), 32'h1);
        check("t2_g1_b", 32'(b_ready), 32'h0);
        tick();
        a_tgt = 3'd2; a_dat = 16'h0002;
        #1;
        check("t2_w1_we", 32'(rf_we), 32'h1);
        check("t2_w1_tgt", 32'(rf_tgt), 32'h1);
        check("t2_w1_dat", 32'(rf_dat), 32'h0001);
        check("t2_g2_a", 32'(a_ready), 32'h0);
        check("t2_g2_b", 32'(b_ready), 32'h1);
        tick();
        iss_valid = 1'b1; iss_tgt = 3'd5;
        #1;
        check("t2_w2_tgt", 32'(rf_tgt), 32'h5);
        check("t2_w2_dat", 32'(rf_dat), 32'hBEEF);
        check("t2_busy_k3", 32'(busy), 32'h24);
        check("t2_g3_a", 32'(a_ready), 32'h1);
        check("t2_g3_b", 32'(b_ready), 32'h0);
        check("t2_waw_stall", 32'(iss_stall), 32'h1);
        tick();
        a_tgt = 3'd0; a_dat = 16'hAAAA;
        #1;
        check("t2_w3_tgt", 32'(rf_tgt), 32'h2);
        check("t2_w3_dat", 32'(rf_dat), 32'h0002);
        check("t2_busy_k4", 32'(busy), 32'h04);
        check("t2_stall_rel", 32'(iss_stall), 32'h0);
        check("t2_g4_a", 32'(a_ready), 32'h0);
        check("t2_g4_b", 32'(b_ready), 32'h1);
        tick();
        b_valid = 1'b0; iss_valid = 1'b0; iss_tgt = 3'd0;
        #1;
        check("t2_w4_we", 32'(rf_we), 32'h1);
        check("t2_w4_tgt", 32'(rf_tgt), 32'h5);
        check("t2_busy_k5", 32'(busy), 32'h20);
        check("t2_err_k5", 32'(wb_err), 32'h0);
        check("t2_zero_grant", 32'(a_ready), 32'h1);
        tick();
        a_valid = 1'b0;
        #1;
        check("t2_zero_no_we", 32'(rf_we), 32'h0);
        check("t2_zero_tgt_hold", 32'(rf_tgt), 32'h5);
        check("t2_busy_k6", 32'(busy), 32'h00);
        check("t2_zero_no_err", 32'(wb_err), 32'h0);

        // RAW stall held through the rf_we cycle, released the cycle after.
        iss_valid = 1'b1; iss_tgt = 3'd4;
        #1 check("t3_issue", 32'(iss_stall), 32'h0);
        tick();
        iss_src1 = 3'd4; iss_tgt = 3'd0;
        b_valid = 1'b1; b_tgt = 3'd4; b_dat = 16'h00FF;
        #1;
        check("t3_raw_stall", 32'(iss_stall), 32'h1);
        check("t3_busy", 32'(busy), 32'h10);
        check("t3_b_ready", 32'(b_ready), 32'h1);
        tick();
        b_valid = 1'b0;
        #1;
        check("t3_rf_we", 32'(rf_we), 32'h1);
        check("t3_rf_dat", 32'(rf_dat), 32'h00FF);
        check("t3_stall_in_we", 32'(iss_stall), 32'h1);
        tick();
        #1;
        check("t3_stall_drop", 32'(iss_stall), 32'h0);
        check("t3_busy_clr", 32'(busy), 32'h00);
        iss_valid = 1'b0; iss_src1 = 3'd0;

        // Fill r1..r7, then zero-register issue and zero-register writeback.
        for (int t = 1; t < 8; t++) begin
            iss_valid = 1'b1; iss_tgt = 3'(t);
            tick();
        end
        iss_tgt = 3'd0;
        a_valid = 1'b1; a_tgt = 3'd0; a_dat = 16'h0BAD;
        #1;
        check("t4_busy_fe", 32'(busy), 32'hFE);
        check("t4_zero_stall", 32'(iss_stall), 32'h0);
        check("t4_a_ready", 32'(a_ready), 32'h1);
        tick();
        a_valid = 1'b0; iss_src2 = 3'd3;
        #1;
        check("t4_busy_same", 32'(busy), 32'hFE);
        check("t4_src2_stall", 32'(iss_stall), 32'h1);
        check("t4_no_we", 32'(rf_we), 32'h0);
        check("t4_no_err", 32'(wb_err), 32'h0);
        iss_valid = 1'b0; iss_src2 = 3'd0;

        pulse_reset();

        // Unexpected write raises sticky wb_err; same-edge set beats clear; reset mid-write.
        a_valid = 1'b1; a_tgt = 3'd6; a_dat = 16'h6666;
        #1;
        check("t5_a_ready", 32'(a_ready), 32'h1);
        check("t5_err_pre", 32'(wb_err), 32'h0);
        tick();
        a_valid = 1'b0;
        iss_valid = 1'b1; iss_tgt = 3'd6;
        #1;
        check("t5_err_set", 32'(wb_err), 32'h1);
        check("t5_rf_we", 32'(rf_we), 32'h1);
        check("t5_rf_tgt", 32'(rf_tgt), 32'h6);
        check("t5_stall", 32'(iss_stall), 32'h0);
        tick();
        iss_valid = 1'b0; iss_tgt = 3'd0;
        a_valid = 1'b1; a_tgt = 3'd6; a_dat = 16'h7777;
        #1;
        check("t6_set_wins", 32'(busy), 32'h40);
        check("t5_err_sticky", 32'(wb_err), 32'h1);
        check("t5_we_off", 32'(rf_we), 32'h0);
        tick();
        #1;
        check("t5_mid_we", 32'(rf_we), 32'h1);
        check("t5_mid_dat", 32'(rf_dat), 32'h7777);
        rst_n = 1'b0;
        #1;
        check("t5_rst_we", 32'(rf_we), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_err", 32'(wb_err), 32'h0);
        check("t5_rst_ready", 32'(a_ready), 32'h0);
        check("t5_rst_dat", 32'(rf_dat), 32'h0);
        a_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        #1;
        check("t5_post_we", 32'(rf_we), 32'h0);
        check("t5_post_err", 32'(wb_err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
